// File: rtl/piece_draw_engine.sv
// Falling-piece renderer: on each frame tick, erase the cells drawn last pass and
// paint the current piece into the pixel frame buffer through a valid/ready port.
module piece_draw_engine #(
  parameter int          CELL_PX  = 16,
  parameter int          SCREEN_W = 640,
  parameter int          ORIGIN_X = 240,
  parameter int          ORIGIN_Y = 0,
  parameter int          BOARD_W  = 10,
  parameter int          BOARD_H  = 20,
  parameter logic [15:0] BG_COLOR = 16'h0000,
  parameter int          ADDR_W   = 19
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_clk,
  input  logic [6:0]        blockXPos [4],
  input  logic [6:0]        blockYPos [4],
  input  logic [15:0]       blockColor,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [15:0]       fb_data,
  output logic              fb_we,
  input  logic              fb_ready,
  output logic              busy,
  output logic              frame_done
);

  localparam int PXW = (CELL_PX > 1) ? $clog2(CELL_PX) : 1;
  localparam int SH  = $clog2(CELL_PX);
  localparam int AW  = ADDR_W + 4;
  localparam logic [PXW-1:0] PX_MAX = PXW'(CELL_PX - 1);
  localparam logic [6:0]     BW7    = 7'(BOARD_W);
  localparam logic [6:0]     BH7    = 7'(BOARD_H);

  typedef enum logic [2:0] {S_IDLE, S_SNAP, S_ERASE, S_DRAW, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        sync_q;
  logic              tick;
  logic              pending_q, pending_d;
  logic              drawn_valid_q, drawn_valid_d;
  logic [6:0]        drawn_x_q [4];
  logic [6:0]        drawn_y_q [4];
  logic [15:0]       drawn_color_q;
  logic [6:0]        snap_x_q [4];
  logic [6:0]        snap_y_q [4];
  logic [15:0]       snap_color_q;
  logic [1:0]        cell_q, cell_d;
  logic [PXW-1:0]    px_q, px_d, py_q, py_d;
  logic              fb_we_q, fb_we_d;
  logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
  logic [15:0]       fb_data_q, fb_data_d;

  logic              snap_en, commit, snap_same;
  logic              advance, walk_wrap;
  logic [1:0]        nxt_cell;
  logic [PXW-1:0]    nxt_px, nxt_py;
  logic              present, pres_erase, pres_on;
  logic [1:0]        pres_cell;
  logic [PXW-1:0]    pres_px, pres_py;
  logic [6:0]        pres_x, pres_y;

  // Exact address at AW bits; multiply by CELL_PX is a shift.
  function automatic logic [ADDR_W-1:0] pix_addr(input logic [6:0] cx, input logic [6:0] cy,
                                                 input logic [PXW-1:0] ox, input logic [PXW-1:0] oy);
    logic [AW-1:0] row, col, full;
    row  = AW'(ORIGIN_Y) + (AW'(cy) << SH) + AW'(oy);
    col  = AW'(ORIGIN_X) + (AW'(cx) << SH) + AW'(ox);
    full = row * AW'(SCREEN_W) + col;
    return full[ADDR_W-1:0];
  endfunction

  assign tick = sync_q[1] & ~sync_q[2];

  always_comb begin
    snap_same = (snap_color_q == drawn_color_q);
    for (int i = 0; i < 4; i++) begin
      if (snap_x_q[i] != drawn_x_q[i] || snap_y_q[i] != drawn_y_q[i]) snap_same = 1'b0;
    end
  end

  // Next walk position; an off-board cell (fb_we low) jumps straight to the next cell.
  always_comb begin
    advance   = ~fb_we_q | fb_ready;
    nxt_px    = px_q;
    nxt_py    = py_q;
    nxt_cell  = cell_q;
    walk_wrap = 1'b0;
    if (!fb_we_q || (px_q == PX_MAX && py_q == PX_MAX)) begin
      nxt_px    = '0;
      nxt_py    = '0;
      nxt_cell  = cell_q + 2'd1;
      walk_wrap = (cell_q == 2'd3);
    end else if (px_q == PX_MAX) begin
      nxt_px = '0;
      nxt_py = py_q + PXW'(1);
    end else begin
      nxt_px = px_q + PXW'(1);
    end
  end

  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    drawn_valid_d = drawn_valid_q;
    cell_d        = cell_q;
    px_d          = px_q;
    py_d          = py_q;
    fb_we_d       = fb_we_q;
    fb_addr_d     = fb_addr_q;
    fb_data_d     = fb_data_q;
    snap_en       = 1'b0;
    commit        = 1'b0;
    present       = 1'b0;
    pres_erase    = 1'b0;
    pres_cell     = 2'd0;
    pres_px       = '0;
    pres_py       = '0;

    if (tick && state_q != S_IDLE) pending_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (tick || pending_q) begin
          state_d   = S_SNAP;
          snap_en   = 1'b1;
          pending_d = 1'b0;
        end
      end
      S_SNAP: begin
        if (drawn_valid_q && snap_same) begin
          state_d = S_DONE;
        end else if (drawn_valid_q) begin
          state_d    = S_ERASE;
          present    = 1'b1;
          pres_erase = 1'b1;
        end else begin
          state_d = S_DRAW;
          present = 1'b1;
        end
      end
      S_ERASE: begin
        if (advance) begin
          present = 1'b1;
          if (walk_wrap) begin
            state_d = S_DRAW;
          end else begin
            pres_erase = 1'b1;
            pres_cell  = nxt_cell;
            pres_px    = nxt_px;
            pres_py    = nxt_py;
          end
        end
      end
      S_DRAW: begin
        if (advance) begin
          if (walk_wrap) begin
            state_d       = S_DONE;
            fb_we_d       = 1'b0;
            commit        = 1'b1;
            drawn_valid_d = 1'b1;
          end else begin
            present   = 1'b1;
            pres_cell = nxt_cell;
            pres_px   = nxt_px;
            pres_py   = nxt_py;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    pres_x  = pres_erase ? drawn_x_q[pres_cell] : snap_x_q[pres_cell];
    pres_y  = pres_erase ? drawn_y_q[pres_cell] : snap_y_q[pres_cell];
    pres_on = (pres_x < BW7) && (pres_y < BH7);

    if (present) begin
      cell_d  = pres_cell;
      px_d    = pres_px;
      py_d    = pres_py;
      fb_we_d = pres_on;
      if (pres_on) begin
        fb_addr_d = pix_addr(pres_x, pres_y, pres_px, pres_py);
        fb_data_d = pres_erase ? BG_COLOR : snap_color_q;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q       <= S_IDLE;
      sync_q        <= '0;
      pending_q     <= 1'b0;
      drawn_valid_q <= 1'b0;
      cell_q        <= 2'd0;
      px_q          <= '0;
      py_q          <= '0;
      fb_we_q       <= 1'b0;
      fb_addr_q     <= '0;
      fb_data_q     <= '0;
    end else begin
      state_q       <= state_d;
      sync_q        <= {sync_q[1:0], frame_clk};
      pending_q     <= pending_d;
      drawn_valid_q <= drawn_valid_d;
      cell_q        <= cell_d;
      px_q          <= px_d;
      py_q          <= py_d;
      fb_we_q       <= fb_we_d;
      fb_addr_q     <= fb_addr_d;
      fb_data_q     <= fb_data_d;
    end
  end

  // Snapshot and record are only read under drawn_valid / after a snapshot.
  always_ff @(posedge Clk) begin
    if (snap_en) begin
      for (int i = 0; i < 4; i++) begin
        snap_x_q[i] <= blockXPos[i];
        snap_y_q[i] <= blockYPos[i];
      end
      snap_color_q <= blockColor;
    end
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        drawn_x_q[i] <= snap_x_q[i];
        drawn_y_q[i] <= snap_y_q[i];
      end
      drawn_color_q <= snap_color_q;
    end
  end

  assign fb_we      = fb_we_q;
  assign fb_addr    = fb_addr_q;
  assign fb_data    = fb_data_q;
  assign busy       = (state_q != S_IDLE);
  assign frame_done = (state_q == S_DONE);

endmodule

// File: tb/tb_piece_draw_engine.sv
// Bench for piece_draw_engine: directed and random passes scored against a pixel-list model.
module tb_piece_draw_engine;

  localparam int CP = 16, SW = 640, OX = 240, OY = 0, BW = 10, BH = 20;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        frame_clk = 1'b0;
  logic        fb_ready = 1'b1;
  logic [6:0]  bx [4];
  logic [6:0]  by [4];
  logic [15:0] bc;
  logic [18:0] fb_addr;
  logic [15:0] fb_data;
  logic        fb_we, busy, frame_done;

  piece_draw_engine dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
    .blockXPos(bx), .blockYPos(by), .blockColor(bc),
    .fb_addr(fb_addr), .fb_data(fb_data), .fb_we(fb_we), .fb_ready(fb_ready),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 Clk = ~Clk;

  int checks = 0, failures = 0;
  int cyc = 0, done_cnt = 0, wr_cnt = 0, rise_cyc = 0, done_cyc = 0;
  int got_a[$], exp_a[$];
  logic [15:0] got_d[$], exp_d[$];
  int exp_skip, exp_lat;
  bit m_valid = 1'b0;
  int m_x [4];
  int m_y [4];
  logic [15:0] m_col;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  always @(posedge Clk) cyc <= cyc + 1;

  logic prev_stall = 1'b0, prev_busy = 1'b0;
  logic [18:0] prev_addr = '0;
  logic [15:0] prev_data = '0;
  always @(negedge Clk) begin
    if (Reset) begin
      if (prev_stall) begin
        chk("hold_we", int'(fb_we), 1);
        chk("hold_addr", int'(fb_addr), int'(prev_addr));
        chk("hold_data", int'(fb_data), int'(prev_data));
      end
      if (fb_we && fb_ready) begin
        got_a.push_back(int'(fb_addr));
        got_d.push_back(fb_data);
        wr_cnt++;
      end
      if (busy && !prev_busy) rise_cyc = cyc;
      if (frame_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
    prev_stall = Reset && fb_we && !fb_ready;
    prev_addr  = fb_addr;
    prev_data  = fb_data;
    prev_busy  = busy;
  end

  // Reference: list every pixel write of a pass from the board geometry.
  task automatic add_cell(input int x, input int y, input logic [15:0] col);
    if (x >= BW || y >= BH) exp_skip++;
    else
      for (int r = 0; r < CP; r++)
        for (int c = 0; c < CP; c++) begin
          exp_a.push_back((OY + y * CP + r) * SW + OX + x * CP + c);
          exp_d.push_back(col);
        end
  endtask

  task automatic model_pass();
    bit same;
    exp_a.delete(); exp_d.delete(); exp_skip = 0;
    same = m_valid && (m_col == bc);
    for (int c = 0; c < 4; c++)
      if (m_x[c] != int'(bx[c]) || m_y[c] != int'(by[c])) same = 1'b0;
    if (!same) begin
      if (m_valid) for (int c = 0; c < 4; c++) add_cell(m_x[c], m_y[c], 16'h0000);
      for (int c = 0; c < 4; c++) add_cell(int'(bx[c]), int'(by[c]), bc);
      for (int c = 0; c < 4; c++) begin
        m_x[c] = int'(bx[c]);
        m_y[c] = int'(by[c]);
      end
      m_col = bc;
      m_valid = 1'b1;
    end
    exp_lat = exp_a.size() + exp_skip + 1;
  endtask

  task automatic cmp_seq(input string tag);
    int nbad, i0;
    nbad = 0; i0 = 0;
    chk({tag, "_count"}, got_a.size(), exp_a.size());
    for (int i = 0; i < got_a.size() && i < exp_a.size(); i++)
      if (got_a[i] != exp_a[i] || got_d[i] != exp_d[i]) begin
        if (nbad == 0) i0 = i;
        nbad++;
      end
    chk({tag, "_addr_at_first_diff"}, got_a[i0], exp_a[i0]);
    chk({tag, "_data_at_first_diff"}, int'(got_d[i0]), int'(exp_d[i0]));
    chk({tag, "_diffs"}, nbad, 0);
  endtask

  task automatic run_pass(input string tag, input bit rnd, input bit chk_lat);
    int d0, n;
    got_a.delete(); got_d.delete();
    model_pass();
    d0 = done_cnt;
    @(posedge Clk); #1;
    frame_clk = 1'b1;
    n = 0;
    while (done_cnt == d0 && n < 20000) begin
      @(posedge Clk); #1;
      n++;
      if (n == 4) frame_clk = 1'b0;
      fb_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    frame_clk = 1'b0;
    chk({tag, "_timeout"}, int'(n < 20000), 1);
    repeat (5) begin @(posedge Clk); #1; fb_ready = 1'b1; end
    cmp_seq(tag);
    chk({tag, "_done_pulses"}, done_cnt - d0, 1);
    chk({tag, "_idle"}, int'(busy), 0);
    if (chk_lat) chk({tag, "_latency"}, done_cyc - rise_cyc, exp_lat);
  endtask

  task automatic set_blocks(input int x0, y0, x1, y1, x2, y2, x3, y3, input logic [15:0] col);
    bx[0] = 7'(x0); by[0] = 7'(y0); bx[1] = 7'(x1); by[1] = 7'(y1);
    bx[2] = 7'(x2); by[2] = 7'(y2); bx[3] = 7'(x3); by[3] = 7'(y3);
    bc = col;
  endtask

  initial begin
    int d0, n, w0, bad_rows, ndraw;
    set_blocks(0, 0, 0, 0, 0, 0, 0, 0, 16'h0000);
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_we", int'(fb_we), 0);
    chk("rst_addr", int'(fb_addr), 0);
    chk("rst_data", int'(fb_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(frame_done), 0);
    Reset = 1'b1;
    repeat (3) @(posedge Clk);

    // First pass: draw only
    set_blocks(4, 0, 4, 1, 5, 1, 5, 2, 16'h0f00);
    run_pass("first", 1'b0, 1'b1);
    chk("first_addr0", got_a[0], 304);
    chk("first_addr_last", got_a[got_a.size() - 1], 30415);

    // Move right by one: erase then draw
    for (int i = 0; i < 4; i++) bx[i] = bx[i] + 7'd1;
    run_pass("move", 1'b0, 1'b1);

    run_pass("same", 1'b0, 1'b1);

    // Back-pressure on a move back to the original place
    for (int i = 0; i < 4; i++) bx[i] = bx[i] - 7'd1;
    run_pass("bp", 1'b1, 1'b0);

    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 4; i++) begin
        bx[i] = 7'($urandom_range(0, 11));
        by[i] = 7'($urandom_range(0, 21));
      end
      bc = 16'($urandom_range(1, 65535));
      run_pass("rand", 1'b1, 1'b0);
    end

    // Block 3 on row 20 is skipped
    set_blocks(2, 3, 3, 3, 4, 3, 2, 20, 16'h00f0);
    run_pass("oob", 1'b0, 1'b1);
    bad_rows = 0; ndraw = 0;
    foreach (got_a[i]) begin
      if (got_a[i] >= 20 * CP * SW) bad_rows++;
      if (got_d[i] == 16'h00f0) ndraw++;
    end
    chk("oob_row20_writes", bad_rows, 0);
    chk("oob_draw_writes", ndraw, 768);

    // Two ticks during a pass produce exactly one extra (unchanged) pass
    set_blocks(6, 5, 7, 5, 6, 6, 7, 6, 16'h1234);
    got_a.delete(); got_d.delete();
    model_pass();
    d0 = done_cnt;
    @(posedge Clk); #1; frame_clk = 1'b1;
    repeat (4) @(posedge Clk);
    #1; frame_clk = 1'b0;
    repeat (40) @(posedge Clk);
    for (int p = 0; p < 2; p++) begin
      #1; frame_clk = 1'b1;
      repeat (4) @(posedge Clk);
      #1; frame_clk = 1'b0;
      repeat (4) @(posedge Clk);
    end
    n = 0;
    while (done_cnt < d0 + 2 && n < 8000) begin @(posedge Clk); n++; end
    chk("dbl_timeout", int'(n < 8000), 1);
    repeat (40) @(posedge Clk);
    #1;
    chk("dbl_done_pulses", done_cnt - d0, 2);
    cmp_seq("dbl");
    chk("dbl_idle", int'(busy), 0);

    // Reset in the middle of a pass
    set_blocks(1, 10, 2, 10, 3, 10, 4, 10, 16'h0a0a);
    w0 = wr_cnt;
    @(posedge Clk); #1; frame_clk = 1'b1;
    n = 0;
    while (wr_cnt - w0 < 500 && n < 8000) begin
      @(posedge Clk); #1;
      n++;
      if (n == 4) frame_clk = 1'b0;
    end
    frame_clk = 1'b0;
    chk("rstmid_timeout", int'(n < 8000), 1);
    #2; Reset = 1'b0;
    #1;
    chk("rstmid_we", int'(fb_we), 0);
    chk("rstmid_busy", int'(busy), 0);
    repeat (3) @(posedge Clk);
    #1; Reset = 1'b1;
    m_valid = 1'b0;
    repeat (3) @(posedge Clk);
    run_pass("post_rst", 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/piece_draw_engine.md
# piece_draw_engine

Consumer of the falling-piece outputs of the game logic. On each frame tick it snapshots the four block cell coordinates and the piece colour. It then erases the cells it drew on the previous pass, and paints the new cells as CELL_PX×CELL_PX squares into the pixel frame buffer through a valid/ready write port. It sits between the game logic and the frame-buffer write arbiter, so the VGA scan-out always sees the current piece without redrawing the whole board.

## Interface
Parameters:
- CELL_PX, 16: pixel edge of one board cell (power of two).
- SCREEN_W, 640: frame-buffer row pitch in pixels.
- ORIGIN_X, 240: pixel x of board cell column 0.
- ORIGIN_Y, 0: pixel y of board cell row 0.
- BOARD_W, 10: columns; cells with x ≥ BOARD_W are never written.
- BOARD_H, 20: rows; cells with y ≥ BOARD_H are never written.
- BG_COLOR, 16'h0000: erase colour.
- ADDR_W, 19: frame-buffer address width.

Ports:
- Clk  in  1  system clock; all logic is on its rising edge.
- Reset  in  1  asynchronous, active-low reset.
- frame_clk  in  1  frame tick, level; synchronised internally.
- blockXPos[4]  in  7 each  cell column of blocks 0..3.
- blockYPos[4]  in  7 each  cell row of blocks 0..3.
- blockColor  in  16  piece colour.
- fb_addr  out  ADDR_W  pixel address.
- fb_data  out  16  pixel colour.
- fb_we  out  1  write valid.
- fb_ready  in  1  write accepted this cycle when fb_we=1.
- busy  out  1  high whenever state ≠ IDLE.
- frame_done  out  1  one-cycle pulse at the end of each pass.

## Operation
- frame_clk passes through a 2-flop synchroniser followed by a rising-edge detector. This produces `tick`.
- Internal record: drawn_x[4], drawn_y[4], drawn_color, drawn_valid. Reset leaves drawn_valid at 0.
- States:
  - IDLE → SNAP on tick or pending.
  - SNAP: latch the inputs into snap_x/snap_y/snap_color and clear pending. Go to DONE if drawn_valid=1 and the snapshot equals the record exactly. Otherwise go to ERASE if drawn_valid=1, else to DRAW.
  - ERASE: walk cells 0..3 of the record, writing BG_COLOR.
  - DRAW: walk cells 0..3 of the snapshot, writing snap_color. On exit, copy the snapshot into the record and set drawn_valid=1.
  - DONE: frame_done=1 for one cycle, then → IDLE.
- Per-cell walk: pixels are written row-major, px = 0..CELL_PX-1 inner, py outer.
- Address formula: fb_addr = (ORIGIN_Y + y·CELL_PX + py)·SCREEN_W + ORIGIN_X + x·CELL_PX + px.
  - The computation is exact at ≥ ADDR_W+4 bits, then truncated to ADDR_W.
  - The multiply by CELL_PX is a shift.
- Out-of-board cell (x ≥ BOARD_W or y ≥ BOARD_H): consumes exactly one cycle with fb_we=0, then the walk advances to the next cell.
- Overlap between erased and drawn cells needs no special handling: DRAW follows ERASE, so the final pixels are correct.

## Timing
- Reset values: fb_we=0, fb_addr=0, fb_data=0, busy=0, frame_done=0, state IDLE, pending=0, drawn_valid=0.
- Assertion of Reset mid-pass aborts the pass immediately. fb_we drops asynchronously and no further writes occur.
- Tick latency: a frame_clk rise is sampled, and the tick is seen 3 Clk edges later, at most. SNAP follows tick by 1 cycle.
- Write handshake:
  - fb_addr, fb_data and fb_we are registered.
  - While fb_we=1 and fb_ready=0, all three hold stable.
  - A write completes on a Clk edge with fb_we=1 and fb_ready=1. The next pixel is presented in the following cycle with no bubble, so sustained throughput is one pixel per cycle.
- Pass length with fb_ready held at 1 and all cells on board:
  - Full erase+draw: SNAP at T, writes occupy T+1..T+8·CELL_PX², frame_done at T+8·CELL_PX²+1, IDLE at the next cycle. With CELL_PX=16 that is 2048 writes and frame_done at T+2049.
  - First pass after reset: draw only, 4·CELL_PX² writes.
  - Unchanged snapshot: SNAP → DONE, frame_done at T+1, zero writes.
- A tick arriving while busy sets pending. It is serviced immediately after DONE→IDLE. Further ticks while pending=1 are dropped.
- A tick arriving in the same cycle as DONE sets pending.

## Test plan
- First pass: release Reset, keep fb_ready=1, set blocks (4,0),(4,1),(5,1),(5,2) with colour 16'h0f00, pulse frame_clk. Required: exactly 1024 writes, all with data 16'h0f00. The first write goes to address 304, the last to (47·640)+335=30415. frame_done pulses once.
- Move pass: shift all X by +1, pulse frame_clk. Required: 1024 writes of 16'h0000 at the old cells, followed by 1024 writes of 16'h0f00 at the new cells.
- Unchanged pass: pulse frame_clk with no input change. Required: zero fb_we cycles and frame_done 2 cycles after the tick.
- Back-pressure: drive fb_ready with a random 50% pattern. Required:
  - fb_addr and fb_data never change while fb_we=1 and fb_ready=0.
  - The write sequence is identical to the fb_ready=1 case.
- Out of board and overlap:
  - Set block 3 to y=20. Required: 768 draw writes, no address computed from row 20, and no missing cycle for cells 0..2.
  - Tick twice during a pass. Required: exactly one extra pass follows.
- Reset mid-pass: assert Reset after 500 writes. Required:
  - fb_we=0 the same cycle and busy=0.
  - The next tick produces a draw-only pass of 1024 writes.
